// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake and data_mem bus for lsu_ctrl.
// slave is the LSU side; master is the pipeline plus memory side.
interface lsu_ctrl_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [3:0]        mem_strobe;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_strobe, mem_addr, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_strobe, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-at-a-time load/store unit between execute stage and data_mem.
// Checks legality, drives lane-replicated stores, extends loads, holds a registered response.
module lsu_ctrl #(parameter int ADDR_W = 32) (
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
    logic [1:0]        state_q, state_d;
    logic              we_q, err_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q, wdata_rep, load_ext;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [3:0]        strobe;
    logic              bad_f3, misaligned, illegal, take;
    assign bad_f3     = bus.req_we ? (bus.req_funct3[2] | &bus.req_funct3[1:0])
                                   : (bus.req_funct3 == 3'b011 | &bus.req_funct3[2:1]);
    assign misaligned = (bus.req_funct3[1:0] == 2'b01 & bus.req_addr[0])
                      | (bus.req_funct3[1:0] == 2'b10 & |bus.req_addr[1:0]);
    assign illegal    = bad_f3 | misaligned;
    assign take       = state_q == IDLE & bus.req_valid;
    assign wdata_rep  = bus.req_funct3[1:0] == 2'b00 ? {4{bus.req_wdata[7:0]}}
                      : bus.req_funct3[1:0] == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    assign byte_sel   = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel   = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    // funct3[2] marks the unsigned variants, so it gates the sign bit
    assign load_ext   = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_sel[7]}}, byte_sel}
                      : f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_sel[15]}}, half_sel} : bus.mem_rdata;
    assign strobe     = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
                      : f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    always_comb begin
        state_d = state_q == IDLE   ? (bus.req_valid ? (illegal ? RESP : ACCESS) : IDLE)
                : state_q == ACCESS ? RESP
                : (bus.resp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take && !illegal) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= wdata_rep;
            end
            if (take && illegal) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end
            if (state_q == ACCESS) begin
                rdata_q <= we_q ? 32'd0 : load_ext;
                err_q   <= 1'b0;
            end
        end
    end
    assign bus.req_ready  = state_q == IDLE;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_we     = state_q == ACCESS & we_q;
    assign bus.mem_strobe = bus.mem_we ? strobe : 4'b0000;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
endmodule
